// File: rtl/note_step_sequencer.sv
// Step sequencer: plays a stored NSTEPS x NNOTES pattern at a programmable tempo, merged with live keys.
// Latency: note_enn is registered, one clk after keys_n or a state change; step/step_pulse update on the entry edge.
// Backpressure: none; pattern writes are accepted every cycle in any state.
module note_step_sequencer #(
  parameter int NNOTES    = 5,
  parameter int NSTEPS    = 16,
  parameter int SW        = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NNOTES-1:0] keys_n,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_addr,
  input  logic [NNOTES-1:0] wr_data,
  input  logic              play,
  input  logic              restart,
  input  logic [SW-1:0]     len,
  input  logic [7:0]        tempo,
  output logic [NNOTES-1:0] note_enn,
  output logic [SW-1:0]     step,
  output logic              step_pulse,
  output logic              playing
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NOTE = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        tick_cnt_q, tick_cnt_d;
  logic [NNOTES-1:0] cur_mask_q, cur_mask_d;
  logic [NNOTES-1:0] note_enn_q, note_enn_d;
  logic              step_pulse_q, step_pulse_d;
  logic [NNOTES-1:0] pattern_q [NSTEPS];

  logic              tick;
  logic              entry;
  logic [SW-1:0]     entry_step;
  logic [SW-1:0]     adv_step;

  assign tick     = (state_q != IDLE) && (presc_q == PW'(TICK_DIV - 1));
  // >= rather than == so a len shrunk below the current step still wraps.
  assign adv_step = (step_q >= len) ? '0 : step_q + 1'b1;

  // Next-state logic: prescaler, tick counting, step entry and stop handling.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    tick_cnt_d   = tick_cnt_q;
    cur_mask_d   = cur_mask_q;
    step_pulse_d = 1'b0;
    entry        = 1'b0;
    entry_step   = '0;
    if (state_q != IDLE) presc_d = tick ? '0 : presc_q + 1'b1;
    else                 presc_d = '0;

    if (!play) begin
      state_d    = IDLE;
      cur_mask_d = '0;
      tick_cnt_d = '0;
    end else if (restart || state_q == IDLE) begin
      entry = 1'b1;
    end else if (tick) begin
      if (state_q == NOTE) begin
        if (tick_cnt_q == tempo) begin
          if (GAP_TICKS > 0) begin
            state_d    = GAP;
            tick_cnt_d = '0;
          end else begin
            entry      = 1'b1;
            entry_step = adv_step;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end else begin
        if (tick_cnt_q == 8'(GAP_TICKS - 1)) begin
          entry      = 1'b1;
          entry_step = adv_step;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
    end

    // Mask is latched from the pre-write RAM contents, so a same-cycle write is not seen.
    if (entry) begin
      state_d      = NOTE;
      step_d       = entry_step;
      cur_mask_d   = pattern_q[entry_step];
      step_pulse_d = 1'b1;
      tick_cnt_d   = '0;
      presc_d      = '0;
    end

    note_enn_d = keys_n & ~((state_q == NOTE) ? cur_mask_q : '0);
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      presc_q      <= '0;
      tick_cnt_q   <= '0;
      cur_mask_q   <= '0;
      note_enn_q   <= '1;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      presc_q      <= presc_d;
      tick_cnt_q   <= tick_cnt_d;
      cur_mask_q   <= cur_mask_d;
      note_enn_q   <= note_enn_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // Pattern storage; cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTEPS; i++) pattern_q[i] <= '0;
    end else if (wr_en) begin
      pattern_q[wr_addr] <= wr_data;
    end
  end

  assign note_enn   = note_enn_q;
  assign step       = step_q;
  assign step_pulse = step_pulse_q;
  assign playing    = (state_q != IDLE);

endmodule

// File: tb/tb_note_step_sequencer.sv
// Self-checking bench for note_step_sequencer with a step-period level scoreboard.
// Latency: expectations are pushed as stimulus is driven and popped one clk edge later.
// Backpressure: none.
module tb_note_step_sequencer;
  localparam int NN = 5;
  localparam int NS = 16;
  localparam int SW = 4;
  localparam int TD = 4;
  localparam int GT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NN-1:0] keys_n;
  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [NN-1:0] wr_data;
  logic          play;
  logic          restart;
  logic [SW-1:0] len;
  logic [7:0]    tempo;
  logic [NN-1:0] note_enn;
  logic [SW-1:0] step;
  logic          step_pulse;
  logic          playing;

  always #5 clk = ~clk;

  note_step_sequencer #(
    .NNOTES(NN), .NSTEPS(NS), .SW(SW), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys_n(keys_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .play(play), .restart(restart), .len(len), .tempo(tempo),
    .note_enn(note_enn), .step(step), .step_pulse(step_pulse), .playing(playing)
  );

  typedef struct packed {
    logic [NN-1:0] nenn;
    logic [SW-1:0] stp;
    logic          pulse;
    logic          play_st;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model, expressed in step-period terms rather than prescaler/tick terms.
  logic [NN-1:0] m_pat [NS];
  bit            m_act;
  int            m_pos;
  logic [SW-1:0] m_step;
  logic [NN-1:0] m_mask;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_pat[i] = '0;
    m_act  = 1'b0;
    m_pos  = 0;
    m_step = '0;
    m_mask = '0;
  endtask

  // Predict the outputs after the coming clock edge from the inputs now driven.
  task automatic model_push();
    int            note_cyc;
    int            period;
    int            nxt;
    logic [NN-1:0] on;
    exp_t          e;
    note_cyc = (int'(tempo) + 1) * TD;
    period   = note_cyc + GT * TD;
    on       = (m_act && m_pos < note_cyc) ? m_mask : '0;
    e.nenn   = keys_n & ~on;
    e.pulse  = 1'b0;
    nxt      = -1;
    if (!play) begin
      m_act  = 1'b0;
      m_mask = '0;
    end else if (restart || !m_act) begin
      nxt = 0;
    end else begin
      m_pos++;
      if (m_pos == period) nxt = (m_step >= len) ? 0 : int'(m_step) + 1;
    end
    if (nxt >= 0) begin
      m_act   = 1'b1;
      m_step  = SW'(nxt);
      m_mask  = m_pat[nxt];
      m_pos   = 0;
      e.pulse = 1'b1;
    end
    if (wr_en) m_pat[wr_addr] = wr_data;
    e.stp     = m_step;
    e.play_st = m_act;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".note_enn"}, 16'(note_enn), 16'(e.nenn));
    chk({tag, ".step"}, 16'(step), 16'(e.stp));
    chk({tag, ".step_pulse"}, 16'(step_pulse), 16'(e.pulse));
    chk({tag, ".playing"}, 16'(playing), 16'(e.play_st));
    wr_en   = 1'b0;
    restart = 1'b0;
  endtask

  task automatic wr(input logic [SW-1:0] a, input logic [NN-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc("write");
  endtask

  initial begin
    rst_n   = 1'b0;
    keys_n  = 5'b11111;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    play    = 1'b0;
    restart = 1'b0;
    len     = '0;
    tempo   = '0;
    model_reset();
    #12;
    chk("rst.note_enn", 16'(note_enn), 16'h1f);
    chk("rst.step", 16'(step), 16'h0);
    chk("rst.playing", 16'(playing), 16'h0);
    chk("rst.step_pulse", 16'(step_pulse), 16'h0);
    rst_n = 1'b1;

    // Basic three-step sequence, then live key merge over NOTE and GAP.
    wr(4'd0, 5'b00001);
    wr(4'd1, 5'b00100);
    wr(4'd2, 5'b10000);
    len   = 4'd2;
    tempo = 8'd1;
    play  = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      if (k == 41) keys_n = 5'b11101;
      cyc("seq");
      if (k == 2)  chk("seq_first_note", 16'(note_enn), 16'h1e);
      if (k == 10) chk("seq_gap", 16'(note_enn), 16'h1f);
      if (k == 13) chk("seq_step1_pulse", 16'({step_pulse, step}), 16'h11);
      if (k == 14) chk("seq_step1_note", 16'(note_enn), 16'h1b);
      if (k == 25) chk("seq_step2_pulse", 16'({step_pulse, step}), 16'h12);
      if (k == 26) chk("seq_step2_note", 16'(note_enn), 16'h0f);
      if (k == 37) chk("seq_wrap", 16'({step_pulse, step}), 16'h10);
      if (k == 41) chk("merge_note", 16'(note_enn), 16'h1c);
      if (k == 47) chk("merge_gap", 16'(note_enn), 16'h1d);
    end

    // Restart in step 2, then write hazard in step 1, then stop.
    restart = 1'b1;
    cyc("restart");
    chk("restart_step", 16'({step_pulse, step}), 16'h10);
    for (int j = 1; j <= 15; j++) begin
      if (j == 13) begin
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 5'b00010;
      end
      cyc("hazard");
      if (j == 13) chk("hazard_hold", 16'(note_enn), 16'h19);
    end
    play = 1'b0;
    cyc("stop");
    chk("stop_step_hold", 16'(step), 16'h1);
    chk("stop_playing", 16'(playing), 16'h0);
    cyc("idle");
    chk("idle_keys", 16'(note_enn), 16'h1d);
    keys_n = 5'b10111;
    cyc("idle_key_change");
    chk("idle_key_follow", 16'(note_enn), 16'h17);

    // Next pass through step 1 shows the written mask.
    keys_n = 5'b11111;
    play   = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc("pass2");
      if (k == 14) chk("hazard_next_pass", 16'(note_enn), 16'h1d);
    end

    // len shrink below the current step.
    play = 1'b0;
    cyc("stop2");
    wr(4'd5, 5'b01000);
    len  = 4'd7;
    play = 1'b1;
    for (int k = 1; k <= 88; k++) begin
      if (k == 64) begin
        chk("shrink_at5", 16'(step), 16'h5);
        len = 4'd2;
      end
      cyc("shrink");
      if (k == 73) chk("shrink_wrap", 16'({step_pulse, step}), 16'h10);
    end

    // Asynchronous reset mid-play.
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.note_enn", 16'(note_enn), 16'h1f);
    chk("midrst.step", 16'(step), 16'h0);
    chk("midrst.playing", 16'(playing), 16'h0);
    chk("midrst.step_pulse", 16'(step_pulse), 16'h0);
    model_reset();
    sb_q.delete();
    len   = 4'd0;
    tempo = 8'd0;
    #2;
    rst_n = 1'b1;

    // len=0, tempo=0 after reset: 8-cycle period on step 0, cleared pattern.
    for (int k = 1; k <= 20; k++) begin
      cyc("len0");
      if (k == 2)  chk("pattern_cleared", 16'(note_enn), 16'h1f);
      if (k == 9)  chk("len0_pulse_a", 16'({step_pulse, step}), 16'h10);
      if (k == 17) chk("len0_pulse_b", 16'({step_pulse, step}), 16'h10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
